// File: rtl/half_adder_pkg.sv
// Shared constants and types for the half_adder slice.
package half_adder_pkg;

  localparam int unsigned HA_DEFAULT_W = 2;
  localparam int unsigned OPCNT_W      = 16;

  typedef enum logic {
    MODE_BITWISE = 1'b0,
    MODE_ARITH   = 1'b1
  } mode_e;

endpackage

// File: rtl/half_adder_if.sv
// Operand/result bundle between a requester and the half_adder datapath.
interface half_adder_if
  import half_adder_pkg::*;
#(
  parameter int unsigned W = HA_DEFAULT_W
) ();

  logic               in_valid;
  logic               mode;
  logic [W-1:0]       a;
  logic [W-1:0]       b;
  logic               out_valid;
  logic [W:0]         sum;
  logic [W:0]         carry;
  logic [OPCNT_W-1:0] op_count;

  modport master (
    output in_valid, mode, a, b,
    input  out_valid, sum, carry, op_count
  );

  modport slave (
    input  in_valid, mode, a, b,
    output out_valid, sum, carry, op_count
  );

endinterface

// File: rtl/half_adder_cell.sv
// One-bit half adder: sum = x ^ y, carry = x & y.
module half_adder_cell (
  input  logic x,
  input  logic y,
  output logic sum,
  output logic carry
);

  assign sum   = x ^ y;
  assign carry = x & y;

endmodule

// File: rtl/half_adder.sv
// Registered per-lane half-add or ripple add, selected per operation by mode.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int unsigned W = HA_DEFAULT_W
) (
  input logic         clk,
  input logic         rst,
  half_adder_if.slave bus
);

  logic [W-1:0] lane_s;
  logic [W-1:0] lane_c;
  logic [W-1:0] rip_s;
  logic [W-1:0] rip_c2;
  logic [W:0]   rip;
  mode_e        mode_s;

  assign rip[0] = 1'b0;
  assign mode_s = mode_e'(bus.mode);

  // The first cell of each ripple stage is also the plain bitwise lane.
  for (genvar i = 0; i < W; i++) begin : g_lane
    half_adder_cell u_h1 (
      .x     (bus.a[i]),
      .y     (bus.b[i]),
      .sum   (lane_s[i]),
      .carry (lane_c[i])
    );

    half_adder_cell u_h2 (
      .x     (lane_s[i]),
      .y     (rip[i]),
      .sum   (rip_s[i]),
      .carry (rip_c2[i])
    );

    assign rip[i+1] = lane_c[i] | rip_c2[i];
  end

  logic               out_valid_d, out_valid_q;
  logic [W:0]         sum_d, sum_q;
  logic [W:0]         carry_d, carry_q;
  logic [OPCNT_W-1:0] op_count_d, op_count_q;

  always_comb begin
    out_valid_d = 1'b0;
    sum_d       = sum_q;
    carry_d     = carry_q;
    op_count_d  = op_count_q;
    if (bus.in_valid) begin
      out_valid_d = 1'b1;
      op_count_d  = op_count_q + OPCNT_W'(1);
      unique case (mode_s)
        MODE_BITWISE: begin
          sum_d   = {1'b0, lane_s};
          carry_d = {1'b0, lane_c};
        end
        MODE_ARITH: begin
          sum_d   = {rip[W], rip_s};
          carry_d = rip;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_q     <= '0;
      op_count_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      op_count_q  <= op_count_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.carry     = carry_q;
  assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_half_adder.sv
// Randomized bench for half_adder against an arithmetic reference model.
module tb_half_adder;
  import half_adder_pkg::*;

  localparam int unsigned W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmp_en = 1'b0;
  int   pass_cnt = 0;
  int   tot_cnt = 0;

  always #5 clk = ~clk;

  half_adder_if #(.W(W)) bus ();

  half_adder #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [W:0] ref_sum(input logic m, input int x, input int y);
    if (m) return (W+1)'(x + y);
    return (W+1)'(x ^ y);
  endfunction

  // Carry into bit i+1 is set when the low i+1 bits of the operands overflow.
  function automatic logic [W:0] ref_carry(input logic m, input int x, input int y);
    logic [W:0] r;
    int md;
    if (!m) return (W+1)'(x & y);
    r = '0;
    for (int i = 0; i < W; i++) begin
      md = 1 << (i + 1);
      if ((x % md) + (y % md) >= md) r[i+1] = 1'b1;
    end
    return r;
  endfunction

  logic       m_ov;
  logic [W:0] m_sum, m_carry;
  int         m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ov <= 1'b0; m_sum <= '0; m_carry <= '0; m_cnt <= 0;
    end else if (bus.in_valid) begin
      m_ov    <= 1'b1;
      m_sum   <= ref_sum(bus.mode, int'(bus.a), int'(bus.b));
      m_carry <= ref_carry(bus.mode, int'(bus.a), int'(bus.b));
      m_cnt   <= (m_cnt + 1) % 65536;
    end else begin
      m_ov <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("out_valid", 32'(bus.out_valid), 32'(m_ov));
      check("sum", 32'(bus.sum), 32'(m_sum));
      check("carry", 32'(bus.carry), 32'(m_carry));
      check("op_count", 32'(bus.op_count), 32'(m_cnt));
    end
  end

  task automatic apply(input logic v, input mode_e m, input logic [W-1:0] x, input logic [W-1:0] y);
    bus.in_valid = v;
    bus.mode     = m;
    bus.a        = x;
    bus.b        = y;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic ov, input logic [W:0] s, input logic [W:0] c);
    check({name, ".ov"}, 32'(bus.out_valid), 32'(ov));
    check({name, ".sum"}, 32'(bus.sum), 32'(s));
    check({name, ".carry"}, 32'(bus.carry), 32'(c));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [W:0] hold_s, hold_c;
    logic [15:0] hold_n;

    bus.in_valid = 1'b0;
    bus.mode     = MODE_BITWISE;
    bus.a        = '0;
    bus.b        = '0;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    expect_out("reset", 1'b0, 3'b000, 3'b000);
    check("reset.cnt", 32'(bus.op_count), 32'd0);
    rst = 1'b0;

    // Truth table in bitwise mode
    apply(1'b1, MODE_BITWISE, 2'd0, 2'd0); expect_out("tt00", 1'b1, 3'b000, 3'b000);
    apply(1'b1, MODE_BITWISE, 2'd0, 2'd1); expect_out("tt01", 1'b1, 3'b001, 3'b000);
    apply(1'b1, MODE_BITWISE, 2'd1, 2'd0); expect_out("tt10", 1'b1, 3'b001, 3'b000);
    apply(1'b1, MODE_BITWISE, 2'd1, 2'd1); expect_out("tt11", 1'b1, 3'b000, 3'b001);
    check("tt.cnt", 32'(bus.op_count), 32'd4);

    apply(1'b1, MODE_ARITH, 2'd3, 2'd1);   expect_out("ar31", 1'b1, 3'b100, 3'b110);
    apply(1'b1, MODE_ARITH, 2'd3, 2'd3);   expect_out("ar33", 1'b1, 3'b110, 3'b110);
    apply(1'b1, MODE_BITWISE, 2'd2, 2'd3); expect_out("bw23", 1'b1, 3'b001, 3'b010);

    // Idle cycles hold results and count
    hold_s = bus.sum; hold_c = bus.carry; hold_n = bus.op_count;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, MODE_ARITH, 2'(i + 1), 2'd3);
      expect_out("idle", 1'b0, hold_s, hold_c);
      check("idle.cnt", 32'(bus.op_count), 32'(hold_n));
    end

    // Async pulse between edges clears outputs at once
    apply(1'b1, MODE_ARITH, 2'd3, 2'd1);
    #2 rst = 1'b1;
    #1 expect_out("apulse", 1'b0, 3'b000, 3'b000);
    check("apulse.cnt", 32'(bus.op_count), 32'd0);
    bus.in_valid = 1'b0;
    #1 rst = 1'b0;
    apply(1'b0, MODE_ARITH, 2'd3, 2'd3);
    expect_out("apulse.after", 1'b0, 3'b000, 3'b000);

    // Capture attempted during reset is discarded
    rst = 1'b1;
    apply(1'b1, MODE_BITWISE, 2'd1, 2'd1);
    expect_out("inrst", 1'b0, 3'b000, 3'b000);
    #1 rst = 1'b0;
    apply(1'b0, MODE_BITWISE, 2'd1, 2'd1);
    check("inrst.after.ov", 32'(bus.out_valid), 32'd0);
    apply(1'b1, MODE_BITWISE, 2'd1, 2'd0);
    expect_out("first", 1'b1, 3'b001, 3'b000);
    check("first.cnt", 32'(bus.op_count), 32'd1);

    // Randomized traffic with occasional async reset pulses
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
      apply(($urandom_range(9) < 7), mode_e'($urandom_range(1)),
            W'($urandom), W'($urandom));
    end

    // op_count wrap
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    for (int i = 0; i < 65535; i++)
      apply(1'b1, mode_e'($urandom_range(1)), W'($urandom), W'($urandom));
    check("wrap.ffff", 32'(bus.op_count), 32'h0000_ffff);
    apply(1'b1, MODE_ARITH, 2'd2, 2'd2);
    check("wrap.zero", 32'(bus.op_count), 32'd0);
    apply(1'b1, MODE_ARITH, 2'd2, 2'd3);
    expect_out("wrap.last", 1'b1, 3'b101, 3'b100);
    check("wrap.one", 32'(bus.op_count), 32'd1);

    apply(1'b0, MODE_BITWISE, 2'd0, 2'd0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
